inst_fetch: RTL and testbench

- Instruction fetch stage; the producer side of the decoder's `inst`/`inst_addr` input.
- Owns the PC and issues single-outstanding word reads to instruction memory over a req/gnt + rvalid handshake.
- Registers each returned instruction with its address into the fetch/decode pipeline register.
- Honours `pause_signal` and `flush_signal` from decode and redirects from execute.

---
 rtl/inst_fetch.sv | 129 ++++++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one word read in flight and registers
// each returned instruction with its address for decode.
module inst_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP        = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pause_signal,
    input  logic            flush_signal,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] jump_addr,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_valid
);

    logic [XLEN-1:0] r_pc;
    logic            r_pend;        // request asserted last cycle but not granted
    logic [XLEN-1:0] r_req_addr;
    logic            r_out;
    logic [XLEN-1:0] r_out_addr;
    logic            r_discard;
    logic            r_skid_v;
    logic [XLEN-1:0] r_skid_data;
    logic [XLEN-1:0] r_skid_addr;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_addr;
    logic            r_inst_valid;

    logic            w_slot_free;
    logic            w_fetch_ok;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_gnt;
    logic            w_resp;
    logic [XLEN-1:0] w_jump_pc;
    logic [XLEN-1:0] w_pc_inc;

    // A returning response frees the single slot in the same cycle, which is
    // what allows back-to-back fetches.
    assign w_slot_free = !r_out || mem_rvalid;
    assign w_fetch_ok  = !jump_flag && (flush_signal || !pause_signal);
    assign w_req       = rst_n && (r_pend || (w_slot_free && w_fetch_ok));
    assign w_addr      = r_pend ? r_req_addr : r_pc;
    assign w_gnt       = w_req && mem_gnt;
    assign w_resp      = mem_rvalid && r_out && !r_discard && !jump_flag && !flush_signal;
    assign w_jump_pc   = {jump_addr[XLEN-1:2], 2'b00};
    assign w_pc_inc    = w_addr + {{(XLEN-3){1'b0}}, 3'd4};

    assign mem_req    = w_req;
    assign mem_addr   = w_addr;
    assign inst       = r_inst;
    assign inst_addr  = r_inst_addr;
    assign inst_valid = r_inst_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_ADDR;
            r_pend     <= 1'b0;
            r_req_addr <= RESET_ADDR;
            r_out      <= 1'b0;
            r_out_addr <= RESET_ADDR;
            r_discard  <= 1'b0;
        end else begin
            r_pend     <= w_req && !mem_gnt;
            r_req_addr <= w_addr;
            if (w_gnt) begin
                r_out      <= 1'b1;
                r_out_addr <= w_addr;
            end else if (mem_rvalid) begin
                r_out <= 1'b0;
            end
            // A held request that predates a redirect must not advance the new pc.
            if (jump_flag)
                r_pc <= w_jump_pc;
            else if (w_gnt && !(r_pend && r_discard))
                r_pc <= w_pc_inc;
            if (jump_flag)
                r_discard <= (r_out && !mem_rvalid) || r_pend;
            else if (mem_rvalid)
                r_discard <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_skid_v     <= 1'b0;
            r_skid_data  <= NOP;
            r_skid_addr  <= '0;
        end else if (jump_flag || flush_signal) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
            r_skid_v     <= 1'b0;
        end else if (pause_signal) begin
            if (w_resp) begin
                r_skid_v    <= 1'b1;
                r_skid_data <= mem_rdata;
                r_skid_addr <= r_out_addr;
            end
        end else if (r_skid_v) begin
            r_inst       <= r_skid_data;
            r_inst_addr  <= r_skid_addr;
            r_inst_valid <= 1'b1;
            r_skid_v     <= w_resp;
            if (w_resp) begin
                r_skid_data <= mem_rdata;
                r_skid_addr <= r_out_addr;
            end
        end else if (w_resp) begin
            r_inst       <= mem_rdata;
            r_inst_addr  <= r_out_addr;
            r_inst_valid <= 1'b1;
        end else begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic against a
// stream-level model (expected address sequence, bubbles, holds, request rules).
module tb_inst_fetch;

    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause_signal = 1'b0, flush_signal = 1'b0, jump_flag = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] inst, inst_addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n), .pause_signal(pause_signal), .flush_signal(flush_signal),
        .jump_flag(jump_flag), .jump_addr(jump_addr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst(inst), .inst_addr(inst_addr), .inst_valid(inst_valid)
    );

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t q[$];

    int total = 0, bad = 0, ncyc = 0, lat = 1, delivered = 0;
    bit rel = 1'b0;
    logic [31:0] exp_addr, req_exp;
    bit exp_known, stale;
    bit p_pause, p_flush, p_jump, p_req, p_gnt, p_ivalid;
    logic [31:0] p_jaddr, p_maddr, p_inst, p_iaddr;
    int jat, ng;
    logic [31:0] got [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, want, ncyc);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a | 32'h13;
    endfunction

    task automatic monitor();
        bit held;
        if (p_jump || p_flush) begin
            chk("bubble_inst", inst, NOPI);
            chk("bubble_valid", {31'd0, inst_valid}, 32'd0);
            if (p_jump) begin
                exp_addr  = {p_jaddr[31:2], 2'b00};
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
        end else if (p_pause) begin
            chk("hold_inst", inst, p_inst);
            chk("hold_addr", inst_addr, p_iaddr);
            chk("hold_valid", {31'd0, inst_valid}, {31'd0, p_ivalid});
        end else if (inst_valid) begin
            if (exp_known) chk("seq_addr", inst_addr, exp_addr);
            chk("seq_data", inst, memf(inst_addr));
            exp_addr  = inst_addr + 32'd4;
            exp_known = 1'b1;
            delivered++;
        end
        held = p_req && !p_gnt;
        if (held) begin
            chk("stable_req", {31'd0, mem_req}, 32'd1);
            chk("stable_addr", mem_addr, p_maddr);
        end
        if (mem_req) begin
            chk("one_outstanding", {31'd0, (q.size() == 0 || mem_rvalid)}, 32'd1);
            if (!held) chk("req_addr", mem_addr, req_exp);
        end
        if (mem_rvalid && q.size() > 0) void'(q.pop_front());
        if (mem_req && mem_gnt) begin
            q.push_back('{addr: mem_addr, due: ncyc + lat});
            if (held && stale) stale = 1'b0;
            else req_exp = mem_addr + 32'd4;
        end
        if (jump_flag) begin
            if (mem_req && !mem_gnt) stale = 1'b1;
            req_exp = {jump_addr[31:2], 2'b00};
        end
        p_pause = pause_signal; p_flush = flush_signal; p_jump = jump_flag; p_jaddr = jump_addr;
        p_req = mem_req; p_gnt = mem_gnt; p_maddr = mem_addr;
        p_inst = inst; p_iaddr = inst_addr; p_ivalid = inst_valid;
    endtask

    task automatic cyc(input bit pa, input bit fl, input bit jp, input logic [31:0] ja, input bit g);
        @(posedge clk); #1;
        if (rel) begin rst_n = 1'b1; rel = 1'b0; end
        pause_signal = pa; flush_signal = fl; jump_flag = jp; jump_addr = ja; mem_gnt = g;
        if (q.size() > 0 && q[0].due <= ncyc) begin
            mem_rvalid = 1'b1; mem_rdata = memf(q[0].addr);
        end else begin
            mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        monitor();
        ncyc++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; pause_signal = 1'b0; flush_signal = 1'b0; jump_flag = 1'b0;
        jump_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_inst", inst, NOPI);
        chk("rst_iaddr", inst_addr, 32'd0);
        chk("rst_ivalid", {31'd0, inst_valid}, 32'd0);
        repeat (2) @(posedge clk);
        q.delete(); ncyc = 0; exp_addr = '0; exp_known = 1'b1; req_exp = '0; stale = 1'b0;
        p_pause = 0; p_flush = 0; p_jump = 0; p_req = 0; p_gnt = 0; p_ivalid = 0;
        p_jaddr = '0; p_maddr = '0; p_inst = NOPI; p_iaddr = '0;
        rel = 1'b1;
    endtask

    initial begin
        // streaming: one instruction per cycle, first valid two cycles after the first request
        lat = 1; do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 32'd0, 1);
            if (k == 0) begin
                chk("t1_first_req", {31'd0, mem_req}, 32'd1);
                chk("t1_first_addr", mem_addr, 32'd0);
            end
            if (k >= 2) begin
                chk("t1_iaddr", inst_addr, 32'(4 * (k - 2)));
                chk("t1_ivalid", {31'd0, inst_valid}, 32'd1);
            end
        end

        // grant stall on address 8
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 32'd0, !(k >= 2 && k <= 4));
            if (k >= 3 && k <= 4) begin
                chk("t2_req_held", {31'd0, mem_req}, 32'd1);
                chk("t2_addr_held", mem_addr, 32'h8);
            end
            if (k >= 4 && k <= 6) chk("t2_bubble", {31'd0, inst_valid}, 32'd0);
            if (k == 6) chk("t2_next_req", mem_addr, 32'hC);
            if (k == 7) chk("t2_resume", inst_addr, 32'h8);
        end

        // pause while the response for 8 is in flight
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(k >= 3 && k <= 6, 0, 0, 32'd0, 1);
            if (k >= 3 && k <= 6) chk("t3_no_req", {31'd0, mem_req}, 32'd0);
            if (k >= 4 && k <= 7) chk("t3_hold4", inst_addr, 32'h4);
            if (k == 7) chk("t3_resume_addr", mem_addr, 32'hC);
            if (k == 8) chk("t3_skid_out", inst_addr, 32'h8);
            if (k == 9) chk("t3_then_c", inst_addr, 32'hC);
        end

        // redirect while 0x10 is outstanding
        lat = 2; do_reset();
        jat = -1; ng = 0; got[0] = '0; got[1] = '0;
        for (int k = 0; k < 30; k++) begin
            cyc(0, 0, jat == k, 32'h103, 1);
            if (jat >= 0 && k == jat + 1) begin
                chk("t4_bubble", {31'd0, inst_valid}, 32'd0);
                chk("t4_req", {31'd0, mem_req}, 32'd1);
                chk("t4_new_addr", mem_addr, 32'h100);
            end
            if (jat >= 0 && k > jat && inst_valid && ng < 2) begin
                got[ng] = inst_addr; ng++;
            end
            if (jat < 0 && mem_req && mem_gnt && mem_addr == 32'h10) jat = k + 1;
        end
        chk("t4_count", 32'(ng), 32'd2);
        chk("t4_first", got[0], 32'h100);
        chk("t4_second", got[1], 32'h104);

        // flush and pause together
        lat = 1; do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(k == 4, k == 4, 0, 32'd0, 1);
            if (k == 5) begin
                chk("t5_inst", inst, NOPI);
                chk("t5_ivalid", {31'd0, inst_valid}, 32'd0);
                chk("t5_pc_kept", mem_addr, 32'h14);
            end
        end

        // wrap-around past the top of the address space
        do_reset();
        ng = 0; got[0] = '1; got[1] = '1;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, k == 2, 32'hFFFF_FFFE, 1);
            if (k == 3) chk("t6_req_top", mem_addr, 32'hFFFF_FFFC);
            if (k == 4) chk("t6_req_wrap", mem_addr, 32'h0);
            if (k > 2 && inst_valid && ng < 2) begin
                got[ng] = inst_addr; ng++;
            end
        end
        chk("t6_first", got[0], 32'hFFFF_FFFC);
        chk("t6_second", got[1], 32'h0);

        // randomized traffic, including a reset mid-operation
        do_reset();
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            lat = int'($urandom_range(1, 3));
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 30) == 0,
                $urandom_range(0, 25) == 0, $urandom, $urandom_range(0, 3) != 0);
        end
        chk("rand_progress", {31'd0, delivered > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
